// File: rtl/led_blink_ctrl.sv
// Multi-channel LED driver: programmable prescaler, shared blink toggle and shared PWM counter.
// Optional build macro LED_ACTIVE_LOW_EN inverts the LED register (stores/drives ~next, resets to all ones).
module led_blink_ctrl #(
    parameter int WIDTH    = 22,
    parameter int NCH      = 4,
    parameter int PWM_BITS = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    EN,
    input  logic [WIDTH-1:0]        DIV,
    input  logic [2*NCH-1:0]        MODE,
    input  logic [PWM_BITS*NCH-1:0] DUTY,
    output logic [NCH-1:0]          LED,
    output logic                    TICK,
    output logic [WIDTH-1:0]        COUNT
);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_PWM   = 2'b11;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [NCH-1:0] LED_RST = '1;
`else
    localparam logic [NCH-1:0] LED_RST = '0;
`endif

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic                blink_q, blink_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                tick_q, tick_d;
    logic [NCH-1:0]      led_q, led_d, led_drive;
    logic                wrap;

    // The >= compare lets a lowered DIV force an immediate wrap instead of running to 2^WIDTH.
    always_comb begin
        wrap      = (cnt_q >= DIV);
        cnt_d     = cnt_q;
        blink_d   = blink_q;
        pwm_cnt_d = pwm_cnt_q;
        tick_d    = 1'b0;
        if (EN) begin
            if (wrap) begin
                cnt_d   = '0;
                blink_d = ~blink_q;
                tick_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
            pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        end
    end

    always_comb begin
        led_d = '0;
        for (int i = 0; i < NCH; i++) begin
            case (MODE[2*i +: 2])
                MODE_OFF:   led_d[i] = 1'b0;
                MODE_ON:    led_d[i] = 1'b1;
                MODE_BLINK: led_d[i] = blink_q;
                MODE_PWM:   led_d[i] = (pwm_cnt_q < DUTY[PWM_BITS*i +: PWM_BITS]);
                default:    led_d[i] = 1'b0;
            endcase
        end
    end

`ifdef LED_ACTIVE_LOW_EN
    assign led_drive = ~led_d;
`else
    assign led_drive = led_d;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q     <= '0;
            blink_q   <= 1'b0;
            pwm_cnt_q <= '0;
            tick_q    <= 1'b0;
            led_q     <= LED_RST;
        end else begin
            cnt_q     <= cnt_d;
            blink_q   <= blink_d;
            pwm_cnt_q <= pwm_cnt_d;
            tick_q    <= tick_d;
            led_q     <= led_drive;
        end
    end

    assign LED   = led_q;
    assign TICK  = tick_q;
    assign COUNT = cnt_q;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl (default parameters); follows LED_ACTIVE_LOW_EN for LED polarity.
module tb_led_blink_ctrl;

  logic        CLK;
  logic        RESET;
  logic        EN;
  logic [21:0] DIV;
  logic [7:0]  MODE;
  logic [31:0] DUTY;
  logic [3:0]  LED;
  logic        TICK;
  logic [21:0] COUNT;

  int checks = 0;
  int errors = 0;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [3:0] LED_INV = 4'hF;
`else
  localparam logic [3:0] LED_INV = 4'h0;
`endif

  // Expected COUNT/TICK/LED for the first ten enabled cycles with DIV=3, all channels blinking.
  int         exp_c[10] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
  logic       exp_t[10] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
  logic [3:0] exp_l[10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0};

  int hi[4];

  led_blink_ctrl dut (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (EN),
    .DIV   (DIV),
    .MODE  (MODE),
    .DUTY  (DUTY),
    .LED   (LED),
    .TICK  (TICK),
    .COUNT (COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic expect_state(input string tag, input int c, input logic t, input logic [3:0] l);
    check({tag, ".count"}, 32'(COUNT), 32'(c));
    check({tag, ".tick"}, 32'(TICK), 32'(t));
    check({tag, ".led"}, 32'(LED), 32'(l ^ LED_INV));
  endtask

  initial begin
    RESET = 1'b1;
    EN    = 1'b0;
    DIV   = 22'd3;
    MODE  = 8'hAA;
    DUTY  = 32'h0;
    cyc(2);
    expect_state("reset", 0, 1'b0, 4'h0);

    // DIV=3 blink: TICK every 4 cycles, LED period 8.
    RESET = 1'b0;
    EN    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      expect_state($sformatf("div3_c%0d", i), exp_c[i], exp_t[i], exp_l[i]);
    end

    // DIV=0: wrap every cycle, LED alternates one cycle behind blink_q.
    DIV = 22'd0;
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      expect_state($sformatf("div0_c%0d", i), 0, 1'b1, (i % 2 == 0) ? 4'hF : 4'h0);
    end

    // DIV=10 to count 8, then lower DIV to 5 forces a wrap.
    DIV = 22'd10;
    cyc(8);
    expect_state("div10_at8", 8, 1'b0, 4'h0);
    DIV = 22'd5;
    cyc(1);
    expect_state("div5_force", 0, 1'b1, 4'h0);
    cyc(5);
    expect_state("div5_c5", 5, 1'b0, 4'hF);
    cyc(1);
    expect_state("div5_wrap", 0, 1'b1, 4'hF);

    // PWM: ch0 duty 0, ch1 duty 64, ch2 duty 255, ch3 on.
    MODE = 8'h7F;
    DUTY = 32'h00FF4000;
    for (int ch = 0; ch < 4; ch++) hi[ch] = 0;
    for (int i = 0; i < 512; i++) begin
      cyc(1);
      for (int ch = 0; ch < 4; ch++) hi[ch] += int'(LED[ch] ^ LED_INV[ch]);
    end
    check("pwm_duty0",   32'(hi[0]), 32'd0);
    check("pwm_duty64",  32'(hi[1]), 32'd128);
    check("pwm_duty255", 32'(hi[2]), 32'd510);
    check("pwm_on",      32'(hi[3]), 32'd512);

    // Mid-run reset with EN=1.
    RESET = 1'b1;
    cyc(1);
    expect_state("midreset", 0, 1'b0, 4'h0);
    RESET = 1'b0;
    MODE  = 8'hAA;
    DIV   = 22'd3;
    DUTY  = 32'h0;
    cyc(4);
    expect_state("restart_wrap", 0, 1'b1, 4'h0);
    cyc(1);
    expect_state("restart_c1", 1, 1'b0, 4'hF);

    // Freeze for 20 cycles; ch0 turned off partway through.
    EN = 1'b0;
    cyc(1);
    expect_state("freeze_c1", 1, 1'b0, 4'hF);
    cyc(9);
    MODE = 8'hA8;
    cyc(1);
    expect_state("freeze_off0", 1, 1'b0, 4'hE);
    cyc(9);
    expect_state("freeze_end", 1, 1'b0, 4'hE);
    EN = 1'b1;
    cyc(1);
    expect_state("resume", 2, 1'b0, 4'hE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
